// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, colour constants and fill bundle type
package vga_pkg;

    localparam int CNT_W       = 10;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 783;

    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 514;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COL_BLACK   = 12'h000;
    localparam rgb_t COL_RED     = 12'hF00;
    localparam rgb_t COL_GREEN   = 12'h0F0;
    localparam rgb_t COL_MAGENTA = 12'hF0F;
    localparam rgb_t COL_YELLOW  = 12'hFF0;
    localparam rgb_t COL_BLUE    = 12'h00F;
    localparam rgb_t COL_WHITE   = 12'hFFF;

    // Fill flags in priority order, highest first.
    typedef struct packed {
        logic lose;
        logic win;
        logic ghost;
        logic pacman;
        logic wall;
        logic dot;
    } fill_t;

endpackage

// File: rtl/pixel_clk_en.sv
// rtl/pixel_clk_en.sv - divides the system clock into a one-cycle pixel enable
module pixel_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // div_cnt sits at 0 during reset, so the enable is low without extra gating.
    assign pix_en = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA scan counters, sync pulses, colour composite and frame tick
module vga_scan_generator #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_VIS_START = vga_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_VIS_START = vga_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_pkg::V_VIS_END
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pacmanFill,
    input  logic        ghostFill,
    input  logic        wallFill,
    input  logic        dotFill,
    input  logic        win,
    input  logic        lose,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic [11:0] rgb,
    output logic        pixEn,
    output logic        frameTick
);

    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SW   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SW   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VS   = CNT_W'(H_VIS_START);
    localparam logic [CNT_W-1:0] H_VE   = CNT_W'(H_VIS_END);
    localparam logic [CNT_W-1:0] V_VS   = CNT_W'(V_VIS_START);
    localparam logic [CNT_W-1:0] V_VE   = CNT_W'(V_VIS_END);

    logic  h_last;
    logic  v_last;
    logic  vis;
    fill_t fills;
    rgb_t  colour;

    pixel_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_en (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pixEn)
    );

    assign h_last    = (hCount == H_LAST);
    assign v_last    = (vCount == V_LAST);
    assign vis       = (hCount >= H_VS) && (hCount <= H_VE) &&
                       (vCount >= V_VS) && (vCount <= V_VE);
    assign frameTick = pixEn && h_last && v_last;

    assign fills = '{lose: lose, win: win, ghost: ghostFill,
                     pacman: pacmanFill, wall: wallFill, dot: dotFill};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCount <= '0;
            vCount <= '0;
        end else if (pixEn) begin
            if (h_last) begin
                hCount <= '0;
                vCount <= v_last ? '0 : vCount + 1'b1;
            end else begin
                hCount <= hCount + 1'b1;
            end
        end
    end

    always_comb begin
        colour = COL_BLACK;
        if (!vis)              colour = COL_BLACK;
        else if (fills.lose)   colour = COL_RED;
        else if (fills.win)    colour = COL_GREEN;
        else if (fills.ghost)  colour = COL_MAGENTA;
        else if (fills.pacman) colour = COL_YELLOW;
        else if (fills.wall)   colour = COL_BLUE;
        else if (fills.dot)    colour = COL_WHITE;
    end

    // Registered from the pre-increment counts, so all four lag the counters by one pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            bright <= 1'b0;
            rgb    <= COL_BLACK;
        end else if (pixEn) begin
            hSync  <= ~(hCount < H_SW);
            vSync  <= ~(vCount < V_SW);
            bright <= vis;
            rgb    <= colour;
        end
    end

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - directed self-checking bench on a reduced scan geometry
module tb_vga_scan_generator;

    // Reduced geometry: line = 100 px = 400 clk, frame = 20 lines = 8000 clk.
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pacmanFill, ghostFill, wallFill, dotFill, win, lose;
    logic [9:0]  hCount, vCount;
    logic        hSync, vSync, bright, pixEn, frameTick;
    logic [11:0] rgb;

    int n_assert = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    int unsigned rel;

    vga_scan_generator #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(100), .H_SYNC(12), .H_VIS_START(18), .H_VIS_END(97),
        .V_TOTAL(20), .V_SYNC(2), .V_VIS_START(4), .V_VIS_END(17)
    ) dut (
        .clk(clk), .reset(reset),
        .pacmanFill(pacmanFill), .ghostFill(ghostFill), .wallFill(wallFill), .dotFill(dotFill),
        .win(win), .lose(lose),
        .hCount(hCount), .vCount(vCount), .hSync(hSync), .vSync(vSync),
        .bright(bright), .rgb(rgb), .pixEn(pixEn), .frameTick(frameTick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_fills(input logic p, input logic g, input logic w, input logic d);
        pacmanFill = p; ghostFill = g; wallFill = w; dotFill = d;
    endtask

    // Wait for the pixEn that samples (h,v), then step past the edge that registers it.
    task automatic at_pixel(input int h, input int v);
        int n = 0;
        while (!(hCount == 10'(h) && vCount == 10'(v) && pixEn) && n < 9000) begin
            step();
            n++;
        end
        check("reach_pixel", 32'(n < 9000), 32'd1);
        step();
    endtask

    initial begin
        int low_cnt;
        int tick_cnt;
        int tick_k0;
        int tick_k1;
        int wide;
        int n;
        logic prev_tick;

        reset = 1'b1;
        win = 1'b0;
        lose = 1'b0;
        set_fills(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (10) step();
        check("rst_hcount", 32'(hCount), 32'd0);
        check("rst_vcount", 32'(vCount), 32'd0);
        check("rst_hsync", 32'(hSync), 32'd1);
        check("rst_vsync", 32'(vSync), 32'd1);
        check("rst_bright", 32'(bright), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_pixen", 32'(pixEn), 32'd0);
        check("rst_frametick", 32'(frameTick), 32'd0);

        reset = 1'b0;
        rel = cyc;
        step(); step();
        check("pixen_clk2", 32'(pixEn), 32'd0);
        step();
        check("pixen_clk3", 32'(pixEn), 32'd1);
        check("hcount_before_first", 32'(hCount), 32'd0);
        step();
        check("hcount_first", 32'(hCount), 32'd1);
        check("pixen_clk4", 32'(pixEn), 32'd0);
        check("hsync_first_low", 32'(hSync), 32'd0);

        low_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!hSync) low_cnt++;
        end
        check("hsync_low_clks", 32'(low_cnt), 32'd48);

        n = 0;
        while (!(hCount == 10'd99 && pixEn) && n < 500) begin
            step();
            n++;
        end
        check("reach_h_last", 32'(n < 500), 32'd1);
        step();
        check("hwrap_hcount", 32'(hCount), 32'd0);
        check("hwrap_vcount", 32'(vCount), 32'd2);
        check("hwrap_clk", cyc - rel, 32'd800);

        tick_cnt = 0; tick_k0 = -1; tick_k1 = -1; wide = 0; low_cnt = 0;
        prev_tick = 1'b0;
        for (int i = 0; i < 16000; i++) begin
            step();
            if (!vSync) low_cnt++;
            if (frameTick) begin
                if (prev_tick) wide++;
                if (tick_cnt == 0) tick_k0 = int'(cyc - rel);
                else if (tick_cnt == 1) tick_k1 = int'(cyc - rel);
                tick_cnt++;
            end
            prev_tick = frameTick;
        end
        check("vsync_low_clks", 32'(low_cnt), 32'd1600);
        check("tick_count", 32'(tick_cnt), 32'd2);
        check("tick_width", 32'(wide), 32'd0);
        check("first_tick_edge", 32'(tick_k0 + 1), 32'd8000);
        check("tick_spacing", 32'(tick_k1 - tick_k0), 32'd8000);

        set_fills(1'b1, 1'b1, 1'b1, 1'b0);
        at_pixel(50, 8);
        check("rgb_ghost_pri", 32'(rgb), 32'hF0F);
        check("bright_vis", 32'(bright), 32'd1);
        set_fills(1'b0, 1'b0, 1'b1, 1'b0);
        at_pixel(52, 8);
        check("rgb_wall", 32'(rgb), 32'h00F);
        set_fills(1'b1, 1'b1, 1'b1, 1'b0);
        at_pixel(5, 9);
        check("rgb_hblank", 32'(rgb), 32'h000);
        check("bright_hblank", 32'(bright), 32'd0);
        check("hsync_in_pulse", 32'(hSync), 32'd0);
        set_fills(1'b1, 1'b0, 1'b1, 1'b0);
        at_pixel(30, 9);
        check("rgb_pacman", 32'(rgb), 32'hFF0);
        set_fills(1'b0, 1'b0, 1'b0, 1'b1);
        at_pixel(31, 9);
        check("rgb_dot", 32'(rgb), 32'hFFF);

        set_fills(1'b0, 1'b1, 1'b0, 1'b0);
        win = 1'b1;
        at_pixel(40, 9);
        check("rgb_win", 32'(rgb), 32'h0F0);
        lose = 1'b1;
        at_pixel(41, 9);
        check("rgb_win_lose", 32'(rgb), 32'hF00);
        at_pixel(97, 17);
        check("bright_corner", 32'(bright), 32'd1);
        at_pixel(98, 17);
        check("bright_h_end", 32'(bright), 32'd0);
        at_pixel(50, 18);
        check("rgb_vblank", 32'(rgb), 32'h000);
        check("bright_vblank", 32'(bright), 32'd0);
        at_pixel(50, 1);
        check("vsync_line1", 32'(vSync), 32'd0);
        at_pixel(50, 2);
        check("vsync_line2", 32'(vSync), 32'd1);

        win = 1'b0;
        lose = 1'b0;
        set_fills(1'b0, 1'b0, 1'b0, 1'b1);
        at_pixel(60, 10);
        check("rgb_before_reset", 32'(rgb), 32'hFFF);
        step();
        reset = 1'b1;
        #1;
        check("midrst_hcount", 32'(hCount), 32'd0);
        check("midrst_vcount", 32'(vCount), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'd0);
        check("midrst_bright", 32'(bright), 32'd0);
        check("midrst_hsync", 32'(hSync), 32'd1);
        check("midrst_vsync", 32'(vSync), 32'd1);
        check("midrst_pixen", 32'(pixEn), 32'd0);
        repeat (3) step();
        reset = 1'b0;
        rel = cyc;
        step(); step(); step();
        check("rerun_pixen_clk3", 32'(pixEn), 32'd1);
        check("rerun_hsync_high", 32'(hSync), 32'd1);
        step();
        check("rerun_hcount", 32'(hCount), 32'd1);
        check("rerun_vcount", 32'(vCount), 32'd0);
        check("rerun_hsync_low", 32'(hSync), 32'd0);
        check("rerun_vsync_low", 32'(vSync), 32'd0);
        low_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!hSync) low_cnt++;
        end
        check("rerun_hsync_low_clks", 32'(low_cnt), 32'd48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
